mips_fetch_unit: RTL
====================

# mips_fetch_unit

Parametrised instruction-fetch stage for the MIPS core. It replaces the bare PC register and PC+4 adder with a self-contained unit that owns the PC, reads the program ROM, and buffers fetched instructions in a small queue. It hands instructions to decode over a valid/ready handshake and accepts a single resolved redirect (branch, j, jal, jr) from execute, flushing stale entries. It sits between ProgramMemory and the Control/RegisterFile decode logic.

## Interface
- MEMORY_DEPTH, 32: ROM depth in words; legal PC range is RESET_VECTOR .. RESET_VECTOR+4*(MEMORY_DEPTH-1)
- RESET_VECTOR, 32'h0040_0000: PC after reset (text-segment base)
- QUEUE_DEPTH, 2: fetch-queue entries; power of two, ≥2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- imem_addr  out  32  byte address to ProgramMemory; equals PC
- imem_instr  in  32  combinational ROM data for imem_addr
- redirect_valid  in  1  execute resolved a taken branch/jump this cycle
- redirect_pc  in  32  target byte address
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head this cycle
- if_instr  out  32  head instruction
- if_pc  out  32  head instruction address
- if_pc4  out  32  if_pc + 4 (for jal link, branch base)
- fault  out  1  sticky: misaligned redirect or PC out of range
- issued_count  out  32  instructions handed to decode, wraps

## Operation
- Reset (async assert, while low): PC=RESET_VECTOR, queue empty, if_valid=0, if_instr/if_pc/if_pc4=0, fault=0, issued_count=0.
- Fetch: each edge, if !fault, PC in range, and (count<QUEUE_DEPTH or a pop occurs this edge), push {PC, imem_instr}; PC<=PC+4 (mod 2^32).
- Pop: if_valid && if_ready pops head; issued_count increments.
- Simultaneous push and pop on full queue allowed; count unchanged.
- Redirect (highest priority): on edge with redirect_valid, queue flushed (count=0), no push, no pop, issued_count unchanged, PC<=redirect_pc. Head presented that cycle is discarded even if if_ready=1.
- Misaligned redirect (redirect_pc[1:0]≠0): fault<=1, PC unchanged, queue still flushed.
- Out-of-range PC: no push; fault<=1 on that edge. Fetching stops; remaining entries still drain to decode.
- fault is cleared only by reset.
- Queue: circular buffer, read/write pointers of log2(QUEUE_DEPTH) bits wrapping naturally, separate count of log2(QUEUE_DEPTH)+1 bits.

## Timing
- Fetch-to-valid latency: 1 cycle; instruction at PC presented on imem_addr in cycle n is at queue head (if queue was empty) with if_valid=1 in cycle n+1.
- First instruction after reset release: if_valid=1 after the first rising edge.
- Redirect penalty: redirect edge at n → if_valid=0 in n+1 → target instruction valid in n+2.
- Outputs driven from registers only; imem_addr is the PC register; no combinational path from if_ready or redirect_valid to any output.
- Sustained throughput 1 instruction/cycle with if_ready held high.
- Reset asserted mid-operation: all state returns to reset values immediately, in-flight entries lost.

## Structure
- Shared package mips_pkg: RESET_VECTOR default, NOP encoding 32'h0000_0000, queue-entry struct {pc, instr}.
- One sub-module: fetch_queue (parametrised circular FIFO with flush, push, pop, count); PC/fault/counter logic in the top.

## Test plan
- Reset then if_ready=1 for 5 cycles with ROM words 0x20080001.. -> if_pc 0x00400000,0x00400004,… one per cycle; issued_count=5.
- if_ready=0 for 4 cycles after reset -> queue fills to 2, PC stops at 0x00400008, if_valid held, if_instr stable; release -> resumes in order, no loss/duplication.
- redirect_valid with redirect_pc=0x00400040 while queue full -> next cycle if_valid=0, following cycle if_pc=0x00400040; flushed entries never issued.
- redirect_pc=0x00400042 -> fault=1, PC unchanged, queue empty, no further fetches.
- Run sequentially past 0x0040007C (MEMORY_DEPTH=32) -> last valid entry 0x0040007C issued, fault=1, if_valid=0 afterwards.
- Assert reset low mid-stream with queue holding 2 entries -> outputs zero, PC=0x00400000 immediately; fetch restarts after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants and fetch-queue entry type
// Provides the default reset vector, the NOP encoding and the {pc, instr} queue entry.
package mips_pkg;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: ROM, redirect and decode-handshake bundle of the fetch stage
// master: fetch unit (drives imem_addr, if_*, fault, issued_count)
// slave:  surroundings (drive imem_instr, redirect_*, if_ready)
interface mips_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fault;
  logic [31:0] issued_count;
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc4, fault, issued_count,
    input  imem_instr, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc4, fault, issued_count,
    output imem_instr, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched {pc, instr} entries with flush
// Ports: clk, rst_n (async active-low), flush_i, push_i/push_data_i, pop_i,
//        head_o (entry at read pointer), valid_o (non-empty), full_o.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  assign head_o  = mem_q[rd_q];
  assign valid_o = |cnt_q;
  // DEPTH is a power of two, so the count MSB alone marks a full queue
  assign full_o  = cnt_q[AW];
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner, ROM reader and buffered instruction feed to decode
// Ports: clk, reset (async active-low), bus (mips_fetch_unit_if.master):
//        imem_addr/imem_instr to ROM, redirect_valid/redirect_pc from execute,
//        if_valid/if_ready/if_instr/if_pc/if_pc4 to decode, sticky fault, issued_count.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned QUEUE_DEPTH  = 2
) (
  input logic               clk,
  input logic               reset,
  mips_fetch_unit_if.master bus
);
  localparam logic [31:0] PC_SPAN = 32'(4 * MEMORY_DEPTH);
  logic [31:0]  pc_q, pc_d, issued_q, issued_d;
  logic         fault_q, fault_d;
  logic         in_range, misaligned, push, pop, q_valid, q_full;
  fetch_entry_t head, fetched;
  // PCs below the base wrap to a huge offset, so one unsigned compare covers both ends
  assign in_range   = (pc_q - RESET_VECTOR) < PC_SPAN;
  assign misaligned = |bus.redirect_pc[1:0];
  assign pop        = q_valid && bus.if_ready && !bus.redirect_valid;
  assign push       = !bus.redirect_valid && !fault_q && in_range && (!q_full || pop);
  assign fetched    = '{pc: pc_q, instr: bus.imem_instr};
  always_comb begin
    pc_d     = bus.redirect_valid ? (misaligned ? pc_q : bus.redirect_pc) : push ? pc_q + 32'd4 : pc_q;
    fault_d  = fault_q | (bus.redirect_valid ? misaligned : !in_range);
    issued_d = issued_q + {31'b0, pop};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      fault_q  <= 1'b0;
      issued_q <= '0;
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      issued_q <= issued_d;
    end
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (fetched),
    .head_o      (head),
    .valid_o     (q_valid),
    .full_o      (q_full)
  );
  // Head fields read as zero when the queue is empty so flushed entries never leak out
  assign bus.imem_addr    = pc_q;
  assign bus.if_valid     = q_valid;
  assign bus.if_instr     = q_valid ? head.instr : NOP;
  assign bus.if_pc        = q_valid ? head.pc : '0;
  assign bus.if_pc4       = q_valid ? head.pc + 32'd4 : '0;
  assign bus.fault        = fault_q;
  assign bus.issued_count = issued_q;
endmodule
